// File: rtl/frame_buffer_scheduler.sv
// frame_buffer_scheduler
// Shares one burst-oriented frame-memory command port between the image-sensor
// writer and the VGA reader, and triple-buffers frames so the display never
// shows a partially written frame.
//
// Ports
//   piul1Clock, piul1Reset          clock, synchronous active-high reset
//   piul1WrReq / poul1WrGrant       writer burst request / command-accepted pulse
//   piul1WrFrameStart               sensor frame start, resyncs write offset
//   piul1RdReq / poul1RdGrant       reader burst request / command-accepted pulse
//   piul1RdFrameStart               display vsync, resyncs read offset, swap point
//   poul1MemCmdValid/Write/poulMemAddr, piul1MemCmdReady   memory command port
//   piul1MemBurstDone               last data word of the current burst moved
//   poul2WrBufSel / poul2RdBufSel   buffers being written / displayed
//   poul1FrameDropped               pulse: an unread completed frame was discarded
module frame_buffer_scheduler #(
  parameter int ADDR_W      = 24,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 307200,
  parameter int BUF_STRIDE  = 524288
) (
  input  logic              piul1Clock,
  input  logic              piul1Reset,
  input  logic              piul1WrReq,
  output logic              poul1WrGrant,
  input  logic              piul1WrFrameStart,
  input  logic              piul1RdReq,
  output logic              poul1RdGrant,
  input  logic              piul1RdFrameStart,
  output logic              poul1MemCmdValid,
  input  logic              piul1MemCmdReady,
  output logic              poul1MemCmdWrite,
  output logic [ADDR_W-1:0] poulMemAddr,
  input  logic              piul1MemBurstDone,
  output logic [1:0]        poul2WrBufSel,
  output logic [1:0]        poul2RdBufSel,
  output logic              poul1FrameDropped
);

  localparam logic [ADDR_W-1:0] LAST_OFF  = ADDR_W'(FRAME_WORDS - BURST_LEN);
  localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, CMD, BURST} stateT;

  stateT             state;
  logic [1:0]        wrBufSel, rdBufSel, readyBuf;
  logic              fresh;
  logic [ADDR_W-1:0] wrOffset, rdOffset;
  logic              lastWasRead;
  logic              curWrite;
  logic              burstIsLast;   // current write burst ends a frame
  logic              wrDiscard, rdDiscard;  // frame resync hit an in-flight burst
  logic              cmdValid;
  logic [ADDR_W-1:0] cmdAddr;
  logic              frameDropped;

  function automatic logic [ADDR_W-1:0] nextOffset(input logic [ADDR_W-1:0] off);
    return (off == LAST_OFF) ? '0 : off + BURST_INC;
  endfunction

  function automatic logic [ADDR_W-1:0] bufBase(input logic [1:0] sel);
    return ADDR_W'(sel) * ADDR_W'(BUF_STRIDE);
  endfunction

  // Arbitration: on a tie the requester not served last wins.
  logic              pickRead, launch, accept, burstDone, wrComplete;
  logic [ADDR_W-1:0] wrOffEff, rdOffEff, launchOff;
  logic [1:0]        rdBufEff, launchBuf;

  assign pickRead  = piul1RdReq && (!piul1WrReq || !lastWasRead);
  assign launch    = (state == IDLE) && (piul1WrReq || piul1RdReq);
  // A frame pulse coinciding with launch means the burst belongs to the new frame.
  assign wrOffEff  = piul1WrFrameStart ? '0 : wrOffset;
  assign rdOffEff  = piul1RdFrameStart ? '0 : rdOffset;
  assign rdBufEff  = (piul1RdFrameStart && fresh) ? readyBuf : rdBufSel;
  assign launchOff = pickRead ? rdOffEff : wrOffEff;
  assign launchBuf = pickRead ? rdBufEff : wrBufSel;

  assign accept     = (state == CMD) && cmdValid && piul1MemCmdReady;
  assign burstDone  = (state == BURST) && piul1MemBurstDone;
  assign wrComplete = burstDone && curWrite && burstIsLast && !wrDiscard;

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state        <= IDLE;
      wrBufSel     <= 2'd0;
      rdBufSel     <= 2'd1;
      readyBuf     <= 2'd2;
      fresh        <= 1'b0;
      wrOffset     <= '0;
      rdOffset     <= '0;
      lastWasRead  <= 1'b0;
      curWrite     <= 1'b0;
      burstIsLast  <= 1'b0;
      wrDiscard    <= 1'b0;
      rdDiscard    <= 1'b0;
      cmdValid     <= 1'b0;
      cmdAddr      <= '0;
      frameDropped <= 1'b0;
    end else begin
      frameDropped <= 1'b0;

      case (state)
        IDLE: begin
          if (launch) begin
            curWrite    <= !pickRead;
            cmdAddr     <= bufBase(launchBuf) + launchOff;
            burstIsLast <= !pickRead && (launchOff == LAST_OFF);
            lastWasRead <= pickRead;
            wrDiscard   <= 1'b0;
            rdDiscard   <= 1'b0;
            cmdValid    <= 1'b1;
            state       <= CMD;
          end
        end
        CMD: begin
          if (accept) begin
            cmdValid <= 1'b0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (burstDone) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Offset advance; a frame resync below overrides it.
      if (burstDone && curWrite && !wrDiscard)  wrOffset <= nextOffset(wrOffset);
      if (burstDone && !curWrite && !rdDiscard) rdOffset <= nextOffset(rdOffset);

      if (piul1WrFrameStart) begin
        wrOffset <= '0;
        if (state != IDLE && curWrite) wrDiscard <= 1'b1;
      end
      if (piul1RdFrameStart) begin
        rdOffset <= '0;
        if (state != IDLE && !curWrite) rdDiscard <= 1'b1;
      end

      // Buffer rotation; the three indices stay a permutation of {0,1,2}.
      if (wrComplete && piul1RdFrameStart) begin
        rdBufSel     <= wrBufSel;
        wrBufSel     <= readyBuf;
        readyBuf     <= rdBufSel;
        fresh        <= 1'b0;
        frameDropped <= fresh;
      end else if (wrComplete) begin
        wrBufSel     <= readyBuf;
        readyBuf     <= wrBufSel;
        fresh        <= 1'b1;
        frameDropped <= fresh;
      end else if (piul1RdFrameStart && fresh) begin
        rdBufSel <= readyBuf;
        readyBuf <= rdBufSel;
        fresh    <= 1'b0;
      end
    end
  end

  assign poul1WrGrant      = accept && curWrite;
  assign poul1RdGrant      = accept && !curWrite;
  assign poul1MemCmdValid  = cmdValid;
  assign poul1MemCmdWrite  = curWrite;
  assign poulMemAddr       = cmdAddr;
  assign poul2WrBufSel     = wrBufSel;
  assign poul2RdBufSel     = rdBufSel;
  assign poul1FrameDropped = frameDropped;

endmodule
